// File: rtl/dmem_initiator.sv
// Request-side controller for the data memory strobe/stall protocol: one load or store
// at a time, with misaligned halfwords and words split into sequential byte accesses.
module dmem_initiator #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_mask,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE   = 3'd1;
  localparam logic [2:0] WAIT_HI = 3'd2;
  localparam logic [2:0] WAIT_LO = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  logic [2:0]    state;
  logic          is_write;
  logic          is_split;
  logic          is_signed;
  logic [1:0]    last_idx;
  logic [1:0]    idx;
  logic [1:0]    next_idx;
  logic [31:0]   base_addr;
  logic [31:0]   wdata_q;
  logic [31:0]   rbuf;
  logic [31:0]   rbuf_next;
  logic [31:0]   load_result;
  logic [TW-1:0] timer;
  logic          timer_done;
  logic          accept;
  logic [2:0]    size;
  logic          size_ok;
  logic          split_req;
  logic [1:0]    last_req;

  // Holding ready low while the memory still stalls keeps a fresh strobe from
  // overlapping an access that was in flight across a reset.
  assign req_ready  = (state == IDLE) && !mem_clk_stall;
  assign accept     = req_valid && req_ready;
  assign timer_done = (timer == TIMER_LAST);
  assign next_idx   = idx + 2'd1;

  always_comb begin
    size      = req_mask[2:0];
    size_ok   = (size == 3'b100) || (size == 3'b010) || (size == 3'b001);
    split_req = 1'b0;
    last_req  = 2'd0;
    if (size == 3'b010 && req_addr[0]) begin
      split_req = 1'b1;
      last_req  = 2'd1;
    end else if (size == 3'b100 && req_addr[1:0] != 2'b00) begin
      split_req = 1'b1;
      last_req  = 2'd3;
    end
  end

  // Split loads collect unsigned bytes little-endian; only a half needs extending.
  always_comb begin
    rbuf_next = rbuf;
    rbuf_next[{idx, 3'b000} +: 8] = mem_read_data[7:0];
    if (!is_split)
      load_result = mem_read_data;
    else if (last_idx == 2'd1)
      load_result = {{16{is_signed & rbuf_next[15]}}, rbuf_next[15:0]};
    else
      load_result = rbuf_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      is_write       <= 1'b0;
      is_split       <= 1'b0;
      is_signed      <= 1'b0;
      last_idx       <= 2'd0;
      idx            <= 2'd0;
      base_addr      <= '0;
      wdata_q        <= '0;
      rbuf           <= '0;
      timer          <= '0;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      resp_rdata     <= '0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_sign_mask  <= '0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
    end else begin
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            is_write  <= req_write;
            is_split  <= split_req;
            is_signed <= req_mask[3];
            last_idx  <= last_req;
            idx       <= 2'd0;
            base_addr <= req_addr;
            wdata_q   <= req_wdata;
            rbuf      <= '0;
            if (!size_ok) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= DONE;
            end else begin
              mem_addr       <= req_addr;
              mem_write_data <= split_req ? {24'h0, req_wdata[7:0]} : req_wdata;
              mem_sign_mask  <= split_req ? 4'b0001 : req_mask;
              mem_memread    <= !req_write;
              mem_memwrite   <= req_write;
              state          <= ISSUE;
            end
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (mem_clk_stall) begin
            timer <= '0;
            state <= WAIT_LO;
          end else if (timer_done) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
            state      <= DONE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        WAIT_LO: begin
          if (!mem_clk_stall) begin
            rbuf <= rbuf_next;
            if (idx != last_idx) begin
              idx            <= next_idx;
              mem_addr       <= base_addr + {30'd0, next_idx};
              mem_write_data <= {24'h0, wdata_q[{next_idx, 3'b000} +: 8]};
              mem_sign_mask  <= 4'b0001;
              mem_memread    <= !is_write;
              mem_memwrite   <= is_write;
              state          <= ISSUE;
            end else begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= is_write ? 32'd0 : load_result;
              state      <= DONE;
            end
          end else if (timer_done) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
            state      <= DONE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DONE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
